// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of an N_IN-input gate, settling SETTLE cycles per vector, and
// compares the captured truth table to EXPECTED. Define TRUTH_TABLE_SWEEPER_FAIL_LOG_EN for mismatch logging.
module truth_table_sweeper #(
    parameter int                  N_IN     = 3,
    parameter int                  SETTLE   = 4,
    parameter logic [2**N_IN-1:0]  EXPECTED = 8'h6A
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   signature,
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
    output logic [N_IN-1:0]      first_fail,
    output logic                 fail_valid,
    output logic [N_IN:0]        fail_count,
`endif
    output logic                 pass
);
    localparam int NV = 2**N_IN;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [N_IN-1:0]   r_idx, w_idx_next;
    logic [N_IN-1:0]   r_dut_in, w_dut_in_next;
    logic [7:0]        r_cnt, w_cnt_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              r_pass, w_pass_next;
    logic [NV-1:0]     r_sig, w_sig_next, w_sig_sampled;
    logic              w_last;
    logic              w_settled;

    assign w_last    = (r_idx == N_IN'(NV - 1));
    assign w_settled = (r_cnt == 8'(SETTLE - 1));

    // Signature with the current vector's bit replaced by the live gate output.
    generate
        for (genvar gi = 0; gi < NV; gi++) begin : g_sig_bit
            assign w_sig_sampled[gi] = (r_idx == N_IN'(gi)) ? dut_out : r_sig[gi];
        end
    endgenerate

    always_comb begin
        w_state_next  = r_state;
        w_idx_next    = r_idx;
        w_dut_in_next = r_dut_in;
        w_cnt_next    = r_cnt;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;
        w_pass_next   = r_pass;
        w_sig_next    = r_sig;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_idx_next    = '0;
                    w_dut_in_next = '0;
                    w_cnt_next    = '0;
                    w_sig_next    = '0;
                    w_pass_next   = 1'b0;
                    w_busy_next   = 1'b1;
                    w_state_next  = S_SETTLE;
                end
            end
            S_SETTLE, S_SAMPLE: begin
                if (abort) begin
                    // Abandoned sweep leaves no partial result; dut_in stays put.
                    w_sig_next   = '0;
                    w_pass_next  = 1'b0;
                    w_busy_next  = 1'b0;
                    w_state_next = S_IDLE;
                end else if (r_state == S_SETTLE) begin
                    w_cnt_next = r_cnt + 8'd1;
                    if (w_settled) begin
                        w_state_next = S_SAMPLE;
                    end
                end else begin
                    w_sig_next = w_sig_sampled;
                    if (w_last) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_idx_next    = r_idx + N_IN'(1);
                        w_dut_in_next = r_idx + N_IN'(1);
                        w_cnt_next    = '0;
                        w_state_next  = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                w_done_next  = 1'b1;
                w_pass_next  = (r_sig == EXPECTED);
                w_busy_next  = 1'b0;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_dut_in <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_sig    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_idx    <= w_idx_next;
            r_dut_in <= w_dut_in_next;
            r_cnt    <= w_cnt_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_pass   <= w_pass_next;
            r_sig    <= w_sig_next;
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = r_busy;
    assign done      = r_done;
    assign signature = r_sig;
    assign pass      = r_pass;

`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
    logic [N_IN-1:0] r_first_fail, w_first_fail_next;
    logic            r_fail_valid, w_fail_valid_next;
    logic [N_IN:0]   r_fail_count, w_fail_count_next;
    logic            w_log_clear, w_log_update, w_mismatch;

    assign w_log_clear  = ((r_state == S_IDLE) && start && !abort) ||
                          (((r_state == S_SETTLE) || (r_state == S_SAMPLE)) && abort);
    assign w_log_update = (r_state == S_SAMPLE) && !abort;
    assign w_mismatch   = (dut_out != EXPECTED[r_idx]);

    always_comb begin
        w_first_fail_next = r_first_fail;
        w_fail_valid_next = r_fail_valid;
        w_fail_count_next = r_fail_count;
        if (w_log_clear) begin
            w_first_fail_next = '0;
            w_fail_valid_next = 1'b0;
            w_fail_count_next = '0;
        end else if (w_log_update && w_mismatch) begin
            w_fail_count_next = r_fail_count + (N_IN+1)'(1);
            if (!r_fail_valid) begin
                w_first_fail_next = r_idx;
                w_fail_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_first_fail <= '0;
            r_fail_valid <= 1'b0;
            r_fail_count <= '0;
        end else begin
            r_first_fail <= w_first_fail_next;
            r_fail_valid <= w_fail_valid_next;
            r_fail_count <= w_fail_count_next;
        end
    end

    assign first_fail = r_first_fail;
    assign fail_valid = r_fail_valid;
    assign fail_count = r_fail_count;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized self-checking bench for truth_table_sweeper: three instances (defaults, SETTLE=2, N_IN=2)
// driven by bench-side gate models and checked against a timing-level signature model.
module tb_truth_table_sweeper;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Vector seen by the gate at sample k: the one driven D+1 edges before the sample edge.
    function automatic logic [7:0] model_sig(input logic [7:0] tbl, input int s, input int d,
                                             input int prev, input int nv);
        logic [7:0] r = '0;
        for (int k = 0; k < nv; k++) begin
            int e = (k + 1) * (s + 1) - d - 1;
            int v = (e < 0) ? prev : ((e / (s + 1) > nv - 1) ? nv - 1 : e / (s + 1));
            r[k] = tbl[v];
        end
        return r;
    endfunction

    // ---------------- instance A: defaults ----------------
    logic rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0, dut_out_a;
    logic [2:0] dut_in_a;
    logic busy_a, done_a, pass_a;
    logic [7:0] sig_a;
    logic [7:0] tbl_a = 8'h6A;
    int dly_a = 0;
    int prev_a = 0;
    logic [2:0] pipe_a [0:3];
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
    logic [2:0] ff_a; logic fv_a; logic [3:0] fc_a;
`endif

    always @(posedge clk) begin
        pipe_a[0] <= dut_in_a;
        for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
    end
    always_comb dut_out_a = (dly_a == 0) ? tbl_a[dut_in_a] : tbl_a[pipe_a[dly_a-1]];

    truth_table_sweeper u_a (
        .clk(clk), .reset(rst_a), .start(start_a), .abort(abort_a),
        .dut_in(dut_in_a), .dut_out(dut_out_a), .busy(busy_a), .done(done_a),
        .signature(sig_a),
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
        .first_fail(ff_a), .fail_valid(fv_a), .fail_count(fc_a),
`endif
        .pass(pass_a)
    );

    // ---------------- instance B: SETTLE=2, 3-cycle gate ----------------
    logic rst_b = 1'b1, start_b = 1'b0, dut_out_b;
    logic [2:0] dut_in_b;
    logic busy_b, done_b, pass_b;
    logic [7:0] sig_b;
    logic [7:0] tbl_b = 8'h6A;
    logic [2:0] pipe_b [0:2];
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
    logic [2:0] ff_b; logic fv_b; logic [3:0] fc_b;
`endif

    always @(posedge clk) begin
        pipe_b[0] <= dut_in_b;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    always_comb dut_out_b = tbl_b[pipe_b[2]];

    truth_table_sweeper #(.N_IN(3), .SETTLE(2), .EXPECTED(8'h6A)) u_b (
        .clk(clk), .reset(rst_b), .start(start_b), .abort(1'b0),
        .dut_in(dut_in_b), .dut_out(dut_out_b), .busy(busy_b), .done(done_b),
        .signature(sig_b),
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
        .first_fail(ff_b), .fail_valid(fv_b), .fail_count(fc_b),
`endif
        .pass(pass_b)
    );

    // ---------------- instance C: N_IN=2 XOR gate ----------------
    logic rst_c = 1'b1, start_c = 1'b0, dut_out_c;
    logic [1:0] dut_in_c;
    logic busy_c, done_c, pass_c;
    logic [3:0] sig_c;
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
    logic [1:0] ff_c; logic fv_c; logic [2:0] fc_c;
`endif

    always_comb dut_out_c = dut_in_c[1] ^ dut_in_c[0];

    truth_table_sweeper #(.N_IN(2), .SETTLE(4), .EXPECTED(4'h6)) u_c (
        .clk(clk), .reset(rst_c), .start(start_c), .abort(1'b0),
        .dut_in(dut_in_c), .dut_out(dut_out_c), .busy(busy_c), .done(done_c),
        .signature(sig_c),
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
        .first_fail(ff_c), .fail_valid(fv_c), .fail_count(fc_c),
`endif
        .pass(pass_c)
    );

    // One sweep on A; abort_at/reset_at give the edge (counted from the accept edge) they are sampled at.
    task automatic sweep_a(input logic [7:0] tbl, input int dly, input int abort_at, input int reset_at);
        logic [7:0] exp_sig;
        int stop_at, hold_vec;
        tbl_a = tbl;
        dly_a = dly;
        repeat (5) @(posedge clk);
        exp_sig = model_sig(tbl, 4, dly, prev_a, 8);
        stop_at = 0;
        if (abort_at >= 1 && abort_at <= 40) stop_at = abort_at;
        if (reset_at > 0) stop_at = reset_at;
        hold_vec = (reset_at > 0) ? 0 : (abort_at - 1) / 5;
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1;
        check("accept_busy", busy_a, 1'b1);
        check("accept_dut_in", dut_in_a, 3'd0);
        check("accept_sig", sig_a, 8'h00);
        @(negedge clk) start_a = 1'b0;
        for (int e = 1; e <= 46; e++) begin
            abort_a = (e == abort_at);
            rst_a   = (e == reset_at);
            @(posedge clk); #1;
            if (stop_at > 0 && e >= stop_at) begin
                check($sformatf("stop_busy e%0d", e), busy_a, 1'b0);
                check($sformatf("stop_done e%0d", e), done_a, 1'b0);
                check($sformatf("stop_sig e%0d", e), sig_a, 8'h00);
                check($sformatf("stop_pass e%0d", e), pass_a, 1'b0);
                check($sformatf("stop_dut_in e%0d", e), dut_in_a, hold_vec);
            end else begin
                check($sformatf("busy e%0d", e), busy_a, e < 41);
                check($sformatf("done e%0d", e), done_a, e == 41);
                check($sformatf("dut_in e%0d", e), dut_in_a, (e / 5 > 7) ? 7 : e / 5);
                if (e < 41) check($sformatf("pass_clr e%0d", e), pass_a, 1'b0);
            end
            @(negedge clk);
        end
        abort_a = 1'b0;
        rst_a   = 1'b0;
        if (stop_at == 0) begin
            check("sig", sig_a, exp_sig);
            check("pass", pass_a, exp_sig == 8'h6A);
            prev_a = 7;
        end else begin
            prev_a = hold_vec;
        end
`ifdef TRUTH_TABLE_SWEEPER_FAIL_LOG_EN
        begin
            logic [7:0] diff;
            int first;
            diff  = (stop_at == 0) ? (exp_sig ^ 8'h6A) : 8'h00;
            first = 0;
            for (int k = 7; k >= 0; k--) if (diff[k]) first = k;
            check("fail_valid", fv_a, diff != 0);
            check("first_fail", ff_a, first);
            check("fail_count", fc_a, $countones(diff));
        end
`endif
        $display("[TB] sweep tbl=%02h dly=%0d abort_at=%0d reset_at=%0d sig=%02h pass=%0d",
                 tbl, dly, abort_at, reset_at, sig_a, pass_a);
    endtask

    // start held high: back-to-back sweeps, one done each.
    task automatic back_to_back();
        tbl_a = 8'h6A;
        dly_a = 0;
        repeat (5) @(posedge clk);
        @(negedge clk) start_a = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 86; e++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_done e%0d", e), done_a, (e == 41) || (e == 83));
            check($sformatf("b2b_busy e%0d", e), busy_a, (e != 41) && (e < 83));
            if (e == 41 || e == 83) begin
                check("b2b_sig", sig_a, 8'h6A);
                check("b2b_pass", pass_a, 1'b1);
            end
            @(negedge clk);
            if (e == 83) start_a = 1'b0;
        end
        prev_a = 7;
        $display("[TB] back-to-back sweeps sig=%02h pass=%0d", sig_a, pass_a);
    endtask

    initial begin
        int done_edge;
        logic [7:0] exp_b, tbl_c, exp_c, rnd;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_sig", sig_a, 8'h00);
        check("rst_pass", pass_a, 1'b0);
        check("rst_dut_in", dut_in_a, 3'd0);
        check("rst_b_sig", sig_b, 8'h00);
        check("rst_c_busy", busy_c, 1'b0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        sweep_a(8'h6A, 0, 0, 0);
        sweep_a(8'h00, 0, 0, 0);
        sweep_a(8'h6A, 3, 0, 0);
        sweep_a(8'h6A, 0, 17, 0);
        sweep_a(8'h6A, 0, 0, 0);

        // start and abort together in IDLE: nothing happens.
        repeat (2) @(posedge clk);
        @(negedge clk) begin start_a = 1'b1; abort_a = 1'b1; end
        @(posedge clk); #1;
        check("start_abort_busy", busy_a, 1'b0);
        check("start_abort_dut_in", dut_in_a, 3'd7);
        check("start_abort_pass", pass_a, 1'b1);
        @(negedge clk) begin start_a = 1'b0; abort_a = 1'b0; end
        $display("[TB] start+abort in IDLE busy=%0d dut_in=%0d", busy_a, dut_in_a);

        sweep_a(8'h6A, 0, 0, 30);
        sweep_a(8'h6A, 0, 41, 0);
        sweep_a(8'h6A, 0, 40, 0);
        back_to_back();

        for (int i = 0; i < 8; i++) begin
            rnd = 8'($urandom);
            sweep_a(($urandom_range(0, 1) == 1) ? 8'h6A : rnd,
                    3 * int'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 45)) : 0, 0);
        end

        // Instance B: settle too short for a 3-cycle gate.
        exp_b = model_sig(8'h6A, 2, 3, 0, 8);
        done_edge = -1;
        @(negedge clk) start_b = 1'b1;
        @(posedge clk);
        @(negedge clk) start_b = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (done_b && done_edge < 0) done_edge = e;
        end
        check("b_done_edge", done_edge, 25);
        check("b_sig", sig_b, exp_b);
        check("b_pass", pass_b, exp_b == 8'h6A);
        $display("[TB] short-settle sweep done@%0d sig=%02h pass=%0d", done_edge, sig_b, pass_b);

        // Instance C: 2-input XOR.
        tbl_c = '0;
        for (int k = 0; k < 4; k++) tbl_c[k] = ($countones(k) % 2) == 1;
        exp_c = model_sig(tbl_c, 4, 0, 0, 4);
        done_edge = -1;
        @(negedge clk) start_c = 1'b1;
        @(posedge clk);
        @(negedge clk) start_c = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk); #1;
            if (done_c && done_edge < 0) done_edge = e;
        end
        check("c_done_edge", done_edge, 21);
        check("c_sig", sig_c, exp_c[3:0]);
        check("c_pass", pass_c, exp_c[3:0] == 4'h6);
        $display("[TB] xor sweep done@%0d sig=%01h pass=%0d", done_edge, sig_c, pass_c);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
